// File: rtl/if_id_reg_pkg.sv
// Shared pipeline widths, bubble value and the IF/ID bundle.
// Also used by the other stage registers and the hazard unit.
package if_id_reg_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 64;

  localparam logic [INSTR_W-1:0] BUBBLE_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } if_id_t;

endpackage

// File: rtl/if_id_reg_if.sv
// Fetch/hazard side to IF/ID register signal bundle.
// Master drives fetch data and squash controls; slave returns the registered bundle.
interface if_id_reg_if;
  import if_id_reg_pkg::*;

  logic [INSTR_W-1:0] instruction_in;
  logic [PC_W-1:0]    pc;
  logic               PCSrcD_Control;
  logic               flush;
  logic [INSTR_W-1:0] instruction_out;
  logic [PC_W-1:0]    out_pc;

  modport master (
    output instruction_in,
    output pc,
    output PCSrcD_Control,
    output flush,
    input  instruction_out,
    input  out_pc
  );

  modport slave (
    input  instruction_in,
    input  pc,
    input  PCSrcD_Control,
    input  flush,
    output instruction_out,
    output out_pc
  );

endinterface

// File: rtl/if_id_reg_pipe.sv
// Generic stage register: sync reset and squash both load SQUASH_VAL.
// Shared by all pipeline stage registers.
module if_id_reg_pipe #(
  parameter int           W         = 96,
  parameter logic [W-1:0] SQUASH_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         squash,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SQUASH_VAL;
    end else if (squash) begin
      q <= SQUASH_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: one-cycle capture of instruction and PC.
// Taken branch in decode or a hazard flush loads a bubble.
module if_id_reg #(
  parameter int                 INSTR_W      = if_id_reg_pkg::INSTR_W,
  parameter int                 PC_W         = if_id_reg_pkg::PC_W,
  parameter logic [INSTR_W-1:0] BUBBLE_INSTR = if_id_reg_pkg::BUBBLE_INSTR
) (
  input logic      clk,
  input logic      rst,
  if_id_reg_if.slave bus
);

  localparam int W = INSTR_W + PC_W;
  localparam logic [W-1:0] SQUASH_VAL = {BUBBLE_INSTR, {PC_W{1'b0}}};

  logic         squash;
  logic [W-1:0] d;
  logic [W-1:0] q;

  assign squash = bus.flush | bus.PCSrcD_Control;
  assign d      = {bus.instruction_in, bus.pc};

  if_id_reg_pipe #(
    .W         (W),
    .SQUASH_VAL(SQUASH_VAL)
  ) u_pipe (
    .clk   (clk),
    .rst   (rst),
    .squash(squash),
    .d     (d),
    .q     (q)
  );

  assign bus.instruction_out = q[W-1:PC_W];
  assign bus.out_pc          = q[PC_W-1:0];

endmodule

// File: tb/tb_if_id_reg.sv
// Scoreboard bench for if_id_reg: directed vectors push expected
// bundles, a monitor pops and compares one edge later.
module tb_if_id_reg;
  import if_id_reg_pkg::*;

  logic clk;
  logic rst;

  if_id_reg_if bus ();

  if_id_reg dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  if_id_t exp_q[$];
  string  name_q[$];
  int     n_cmp;
  int     n_bad;

  // Inputs change on the falling edge; expected result is queued then.
  task automatic step(
    input string           nm,
    input logic            r,
    input logic            fl,
    input logic            br,
    input logic [31:0]     ins,
    input logic [63:0]     p,
    input logic [31:0]     e_ins,
    input logic [63:0]     e_pc
  );
    if_id_t e;
    @(negedge clk);
    rst                = r;
    bus.flush          = fl;
    bus.PCSrcD_Control = br;
    bus.instruction_in = ins;
    bus.pc             = p;
    e.instr = e_ins;
    e.pc    = e_pc;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      if_id_t e;
      string  nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_cmp++;
      if (bus.instruction_out !== e.instr || bus.out_pc !== e.pc) begin
        n_bad++;
        $display("FAIL %s: got instr=%h pc=%h, want instr=%h pc=%h",
                 nm, bus.instruction_out, bus.out_pc, e.instr, e.pc);
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst                = 1'b0;
    bus.flush          = 1'b0;
    bus.PCSrcD_Control = 1'b0;
    bus.instruction_in = '0;
    bus.pc             = '0;

    step("reset", 1, 0, 0, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
         32'h0, 64'h0);
    step("capture", 0, 0, 0, 32'h1122_3344, 64'h1234_5678_90AB_CDEF,
         32'h1122_3344, 64'h1234_5678_90AB_CDEF);
    step("branch_squash", 0, 0, 1, 32'h1122_3344, 64'h1234_5678_90AB_CDEF,
         32'h0, 64'h0);
    step("branch_release", 0, 0, 0, 32'h1122_3344, 64'h1234_5678_90AB_CDEF,
         32'h1122_3344, 64'h1234_5678_90AB_CDEF);
    step("flush", 0, 1, 0, 32'h5555_AAAA, 64'h20,
         32'h0, 64'h0);
    step("flush_branch", 0, 1, 1, 32'h5555_AAAA, 64'h24,
         32'h0, 64'h0);
    step("reset_flush", 1, 1, 0, 32'h0000_0005, 64'h5,
         32'h0, 64'h0);
    step("pipe_a", 0, 0, 0, 32'h0000_000A, 64'h0,
         32'h0000_000A, 64'h0);
    step("pipe_b", 0, 0, 0, 32'h0000_000B, 64'h4,
         32'h0000_000B, 64'h4);
    step("pipe_c", 0, 0, 0, 32'h0000_000C, 64'h8,
         32'h0000_000C, 64'h8);
    step("load_dead", 0, 0, 0, 32'hDEAD_BEEF, 64'h100,
         32'hDEAD_BEEF, 64'h100);
    step("mid_reset", 1, 0, 0, 32'h0000_0077, 64'h200,
         32'h0, 64'h0);
    step("post_reset", 0, 0, 0, 32'h0000_0077, 64'h200,
         32'h0000_0077, 64'h200);
    step("flush_hold1", 0, 1, 0, 32'h0000_0099, 64'h300,
         32'h0, 64'h0);
    step("flush_hold2", 0, 1, 0, 32'h0000_0099, 64'h304,
         32'h0, 64'h0);
    step("upper_pc", 0, 0, 0, 32'h0000_0099, 64'hFFFF_0000_0000_0008,
         32'h0000_0099, 64'hFFFF_0000_0000_0008);
    step("after_upper", 0, 0, 0, 32'h8765_4321, 64'h8000_0000_0000_0010,
         32'h8765_4321, 64'h8000_0000_0000_0010);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
